// File: rtl/eth_port_ctrl_pkg.sv
// rtl/eth_port_ctrl_pkg.sv - register offsets, AXI response codes and FSM types for the port control window
package eth_port_ctrl_pkg;

    localparam logic [2:0] REG_ID        = 3'd0;
    localparam logic [2:0] REG_STATUS    = 3'd1;
    localparam logic [2:0] REG_CTRL      = 3'd2;
    localparam logic [2:0] REG_SCRATCH   = 3'd3;
    localparam logic [2:0] REG_RX_FRAMES = 3'd4;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    localparam int CTRL_LOOPBACK_BIT = 0;
    localparam int CTRL_TX_EN_BIT    = 1;

    typedef enum logic [1:0] {
        WR_IDLE,
        WR_HAVE_AW,
        WR_HAVE_W,
        WR_RESP
    } wr_state_t;

    typedef enum logic {
        RD_IDLE,
        RD_RESP
    } rd_state_t;

    function automatic logic [31:0] merge_wstrb(input logic [31:0] cur,
                                                input logic [31:0] wdata,
                                                input logic [3:0]  strb);
        logic [31:0] res;
        for (int b = 0; b < 4; b++) begin
            res[8*b +: 8] = strb[b] ? wdata[8*b +: 8] : cur[8*b +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/eth_port_ctrl_frame_cnt.sv
// rtl/eth_port_ctrl_frame_cnt.sv - saturating clear-on-read received-frame counter
module eth_port_ctrl_frame_cnt (
    input  logic        clk,
    input  logic        reset,
    input  logic        inc,
    input  logic        clr,
    output logic [31:0] count
);

    // A pulse landing on the clearing read is kept so no frame is lost.
    always_ff @(posedge clk) begin
        if (reset) begin
            count <= 32'd0;
        end else if (clr) begin
            count <= {31'd0, inc};
        end else if (inc && (count != 32'hFFFF_FFFF)) begin
            count <= count + 32'd1;
        end
    end

endmodule

// File: rtl/eth_port_ctrl_regs.sv
// rtl/eth_port_ctrl_regs.sv - AXI4-Lite port control registers; ETH_PORT_CTRL_FRAME_CNT_EN enables RX_FRAMES
module eth_port_ctrl_regs
    import eth_port_ctrl_pkg::*;
#(
    parameter int          ADDR_WIDTH = 16,
    parameter logic [31:0] ID_VALUE   = 32'h4554_4831,
    parameter logic [31:0] CTRL_RESET = 32'h0000_0001
) (
    input  logic                  aclk,
    input  logic                  areset,
    input  logic [ADDR_WIDTH-1:0] s_axi_awaddr,
    input  logic                  s_axi_awvalid,
    output logic                  s_axi_awready,
    input  logic [31:0]           s_axi_wdata,
    input  logic [3:0]            s_axi_wstrb,
    input  logic                  s_axi_wvalid,
    output logic                  s_axi_wready,
    output logic [1:0]            s_axi_bresp,
    output logic                  s_axi_bvalid,
    input  logic                  s_axi_bready,
    input  logic [ADDR_WIDTH-1:0] s_axi_araddr,
    input  logic                  s_axi_arvalid,
    output logic                  s_axi_arready,
    output logic [31:0]           s_axi_rdata,
    output logic [1:0]            s_axi_rresp,
    output logic                  s_axi_rvalid,
    input  logic                  s_axi_rready,
    input  logic [7:0]            link_status,
    input  logic                  rx_frame_pulse,
    output logic                  line_loopback_en,
    output logic                  tx_enable
);

    wr_state_t   wr_state, wr_state_nxt;
    rd_state_t   rd_state, rd_state_nxt;
    logic [2:0]  awidx_q;
    logic [31:0] wdata_q;
    logic [3:0]  wstrb_q;
    logic        aw_hs, w_hs, ar_hs, do_write;
    logic [2:0]  wr_idx, rd_idx;
    logic [31:0] wr_data;
    logic [3:0]  wr_strb;
    logic [1:0]  ctrl_q;
    logic [31:0] scratch_q;
    logic [1:0]  bresp_q;
    logic [31:0] rdata_q, rd_data_c;
    logic [1:0]  rresp_q, rd_resp_c;
    logic [31:0] frame_count;
    logic        unused_bits;

    always_comb begin
        wr_state_nxt  = wr_state;
        do_write      = 1'b0;
        s_axi_awready = (wr_state == WR_IDLE) || (wr_state == WR_HAVE_W);
        s_axi_wready  = (wr_state == WR_IDLE) || (wr_state == WR_HAVE_AW);
        aw_hs         = s_axi_awvalid && s_axi_awready;
        w_hs          = s_axi_wvalid && s_axi_wready;
        case (wr_state)
            WR_IDLE: begin
                if (aw_hs && w_hs) begin
                    wr_state_nxt = WR_RESP;
                    do_write     = 1'b1;
                end else if (aw_hs) begin
                    wr_state_nxt = WR_HAVE_AW;
                end else if (w_hs) begin
                    wr_state_nxt = WR_HAVE_W;
                end
            end
            WR_HAVE_AW: if (w_hs) begin
                wr_state_nxt = WR_RESP;
                do_write     = 1'b1;
            end
            WR_HAVE_W: if (aw_hs) begin
                wr_state_nxt = WR_RESP;
                do_write     = 1'b1;
            end
            WR_RESP: if (s_axi_bready) wr_state_nxt = WR_IDLE;
            default: wr_state_nxt = WR_IDLE;
        endcase
    end

    // The beat completing the pair is taken straight from the bus; the earlier one from its holding flop.
    assign wr_idx  = (wr_state == WR_HAVE_AW) ? awidx_q : s_axi_awaddr[4:2];
    assign wr_data = (wr_state == WR_HAVE_W) ? wdata_q : s_axi_wdata;
    assign wr_strb = (wr_state == WR_HAVE_W) ? wstrb_q : s_axi_wstrb;

    always_ff @(posedge aclk) begin
        if (areset) begin
            wr_state  <= WR_IDLE;
            awidx_q   <= 3'd0;
            wdata_q   <= 32'd0;
            wstrb_q   <= 4'd0;
            ctrl_q    <= CTRL_RESET[1:0];
            scratch_q <= 32'd0;
            bresp_q   <= RESP_OKAY;
        end else begin
            wr_state <= wr_state_nxt;
            if (aw_hs) awidx_q <= s_axi_awaddr[4:2];
            if (w_hs) begin
                wdata_q <= s_axi_wdata;
                wstrb_q <= s_axi_wstrb;
            end
            if (do_write) begin
                bresp_q <= ((wr_idx == REG_CTRL) || (wr_idx == REG_SCRATCH)) ? RESP_OKAY : RESP_SLVERR;
                if ((wr_idx == REG_CTRL) && wr_strb[0]) ctrl_q <= wr_data[1:0];
                if (wr_idx == REG_SCRATCH) scratch_q <= merge_wstrb(scratch_q, wr_data, wr_strb);
            end
        end
    end

    assign s_axi_bvalid     = (wr_state == WR_RESP);
    assign s_axi_bresp      = bresp_q;
    assign line_loopback_en = ctrl_q[CTRL_LOOPBACK_BIT];
    assign tx_enable        = ctrl_q[CTRL_TX_EN_BIT];

    assign rd_idx        = s_axi_araddr[4:2];
    assign s_axi_arready = (rd_state == RD_IDLE);
    assign ar_hs         = s_axi_arvalid && s_axi_arready;

    always_comb begin
        rd_data_c = 32'd0;
        rd_resp_c = RESP_OKAY;
        case (rd_idx)
            REG_ID:        rd_data_c = ID_VALUE;
            REG_STATUS:    rd_data_c = {24'd0, link_status};
            REG_CTRL:      rd_data_c = {30'd0, ctrl_q};
            REG_SCRATCH:   rd_data_c = scratch_q;
`ifdef ETH_PORT_CTRL_FRAME_CNT_EN
            REG_RX_FRAMES: rd_data_c = frame_count;
`endif
            default:       rd_resp_c = RESP_SLVERR;
        endcase
    end

    always_comb begin
        rd_state_nxt = rd_state;
        case (rd_state)
            RD_IDLE: if (ar_hs) rd_state_nxt = RD_RESP;
            RD_RESP: if (s_axi_rready) rd_state_nxt = RD_IDLE;
            default: rd_state_nxt = RD_IDLE;
        endcase
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            rd_state <= RD_IDLE;
            rdata_q  <= 32'd0;
            rresp_q  <= RESP_OKAY;
        end else begin
            rd_state <= rd_state_nxt;
            if (ar_hs) begin
                rdata_q <= rd_data_c;
                rresp_q <= rd_resp_c;
            end
        end
    end

    assign s_axi_rvalid = (rd_state == RD_RESP);
    assign s_axi_rdata  = rdata_q;
    assign s_axi_rresp  = rresp_q;

`ifdef ETH_PORT_CTRL_FRAME_CNT_EN
    eth_port_ctrl_frame_cnt u_frame_cnt (
        .clk   (aclk),
        .reset (areset),
        .inc   (rx_frame_pulse),
        .clr   (ar_hs && (rd_idx == REG_RX_FRAMES)),
        .count (frame_count)
    );
    assign unused_bits = ^{s_axi_awaddr[ADDR_WIDTH-1:5], s_axi_awaddr[1:0],
                           s_axi_araddr[ADDR_WIDTH-1:5], s_axi_araddr[1:0]};
`else
    assign frame_count = 32'd0;
    assign unused_bits = ^{s_axi_awaddr[ADDR_WIDTH-1:5], s_axi_awaddr[1:0],
                           s_axi_araddr[ADDR_WIDTH-1:5], s_axi_araddr[1:0],
                           rx_frame_pulse, frame_count};
`endif

endmodule

// File: tb/tb_eth_port_ctrl_regs.sv
// tb/tb_eth_port_ctrl_regs.sv - scoreboard bench for eth_port_ctrl_regs
module tb_eth_port_ctrl_regs;

    logic        aclk = 1'b0;
    logic        areset = 1'b1;
    logic [15:0] s_axi_awaddr = '0;
    logic        s_axi_awvalid = 1'b0;
    logic        s_axi_awready;
    logic [31:0] s_axi_wdata = '0;
    logic [3:0]  s_axi_wstrb = '0;
    logic        s_axi_wvalid = 1'b0;
    logic        s_axi_wready;
    logic [1:0]  s_axi_bresp;
    logic        s_axi_bvalid;
    logic        s_axi_bready = 1'b1;
    logic [15:0] s_axi_araddr = '0;
    logic        s_axi_arvalid = 1'b0;
    logic        s_axi_arready;
    logic [31:0] s_axi_rdata;
    logic [1:0]  s_axi_rresp;
    logic        s_axi_rvalid;
    logic        s_axi_rready = 1'b1;
    logic [7:0]  link_status = 8'h5A;
    logic        rx_frame_pulse = 1'b0;
    logic        line_loopback_en;
    logic        tx_enable;

    int checks = 0;
    int errors = 0;
    logic [1:0]  exp_b[$];
    logic [33:0] exp_r[$];

    eth_port_ctrl_regs dut (
        .aclk(aclk), .areset(areset),
        .s_axi_awaddr(s_axi_awaddr), .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
        .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb), .s_axi_wvalid(s_axi_wvalid),
        .s_axi_wready(s_axi_wready),
        .s_axi_bresp(s_axi_bresp), .s_axi_bvalid(s_axi_bvalid), .s_axi_bready(s_axi_bready),
        .s_axi_araddr(s_axi_araddr), .s_axi_arvalid(s_axi_arvalid), .s_axi_arready(s_axi_arready),
        .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp), .s_axi_rvalid(s_axi_rvalid),
        .s_axi_rready(s_axi_rready),
        .link_status(link_status), .rx_frame_pulse(rx_frame_pulse),
        .line_loopback_en(line_loopback_en), .tx_enable(tx_enable)
    );

    always #5 aclk = ~aclk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    always @(negedge aclk) begin
        if (!areset && s_axi_bvalid && s_axi_bready) begin
            if (exp_b.size() == 0) check_eq("b_unexpected", 1, 0);
            else check_eq("bresp", {62'd0, s_axi_bresp}, {62'd0, exp_b.pop_front()});
        end
        if (!areset && s_axi_rvalid && s_axi_rready) begin
            if (exp_r.size() == 0) check_eq("r_unexpected", 1, 0);
            else check_eq("rresp_rdata", {30'd0, s_axi_rresp, s_axi_rdata}, {30'd0, exp_r.pop_front()});
        end
    end

    // mode 0: AW and W together, 1: W first, 2: AW first
    task automatic axi_write(input logic [15:0] addr, input logic [31:0] data, input logic [3:0] strb,
                             input int mode, input logic [1:0] resp, input int hold,
                             input bit chk_ctrl, input logic [1:0] exp_ctrl);
        bit aw_done = 0, w_done = 0, af, wf, bad = 0;
        logic [1:0] first;
        exp_b.push_back(resp);
        s_axi_awaddr = addr;
        s_axi_wdata  = data;
        s_axi_wstrb  = strb;
        s_axi_bready = (hold == 0);
        if (mode != 2) s_axi_wvalid = 1'b1;
        if (mode != 1) s_axi_awvalid = 1'b1;
        for (int i = 0; i < 20 && !(aw_done && w_done); i++) begin
            @(negedge aclk);
            af = s_axi_awvalid && s_axi_awready;
            wf = s_axi_wvalid && s_axi_wready;
            @(posedge aclk); #1;
            if (af) begin s_axi_awvalid = 1'b0; aw_done = 1; end
            if (wf) begin s_axi_wvalid = 1'b0; w_done = 1; end
            if (w_done && !aw_done && !s_axi_awvalid) s_axi_awvalid = 1'b1;
            if (aw_done && !w_done && !s_axi_wvalid) s_axi_wvalid = 1'b1;
        end
        check_eq("wr_handshake", {62'd0, aw_done, w_done}, 64'd3);
        check_eq("bvalid_rise", {63'd0, s_axi_bvalid}, 64'd1);
        if (chk_ctrl) check_eq("ctrl_update", {62'd0, tx_enable, line_loopback_en}, {62'd0, exp_ctrl});
        if (hold > 0) begin
            first = s_axi_bresp;
            for (int i = 0; i < hold; i++) begin
                @(negedge aclk);
                if (!s_axi_bvalid || s_axi_bresp != first || s_axi_awready || s_axi_wready) bad = 1;
            end
            check_eq("b_hold_stable", {63'd0, bad}, 64'd0);
            @(posedge aclk); #1;
            s_axi_bready = 1'b1;
            @(posedge aclk); #1;
            check_eq("awready_back", {62'd0, s_axi_awready, s_axi_wready}, 64'd3);
        end
        for (int i = 0; i < 20 && s_axi_bvalid; i++) begin
            @(posedge aclk); #1;
        end
        check_eq("bvalid_fall", {63'd0, s_axi_bvalid}, 64'd0);
    endtask

    task automatic axi_read(input logic [15:0] addr, input logic [1:0] resp, input logic [31:0] data,
                            input int hold, input bit pulse);
        bit done = 0, af, bad = 0;
        logic [31:0] first;
        exp_r.push_back({resp, data});
        s_axi_araddr   = addr;
        s_axi_arvalid  = 1'b1;
        s_axi_rready   = (hold == 0);
        rx_frame_pulse = pulse;
        for (int i = 0; i < 20 && !done; i++) begin
            @(negedge aclk);
            af = s_axi_arvalid && s_axi_arready;
            @(posedge aclk); #1;
            rx_frame_pulse = 1'b0;
            if (af) begin s_axi_arvalid = 1'b0; done = 1; end
        end
        check_eq("ar_handshake", {63'd0, done}, 64'd1);
        if (hold > 0) begin
            check_eq("rvalid_rise", {63'd0, s_axi_rvalid}, 64'd1);
            first = s_axi_rdata;
            for (int i = 0; i < hold; i++) begin
                @(negedge aclk);
                if (!s_axi_rvalid || s_axi_rdata != first || s_axi_arready) bad = 1;
            end
            check_eq("r_hold_stable", {63'd0, bad}, 64'd0);
            @(posedge aclk); #1;
            s_axi_rready = 1'b1;
            @(posedge aclk); #1;
            check_eq("arready_back", {63'd0, s_axi_arready}, 64'd1);
        end
        for (int i = 0; i < 20 && s_axi_rvalid; i++) begin
            @(posedge aclk); #1;
        end
        check_eq("rvalid_fall", {63'd0, s_axi_rvalid}, 64'd0);
    endtask

    task automatic frame_pulses(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge aclk); #1 rx_frame_pulse = 1'b1;
            @(posedge aclk); #1 rx_frame_pulse = 1'b0;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (4) @(posedge aclk);
        #1 areset = 1'b0;
        check_eq("rst_ready", {61'd0, s_axi_awready, s_axi_wready, s_axi_arready}, 64'd7);
        check_eq("rst_valid", {62'd0, s_axi_bvalid, s_axi_rvalid}, 64'd0);
        check_eq("rst_resp_data", {28'd0, s_axi_bresp, s_axi_rresp, s_axi_rdata}, 64'd0);
        check_eq("rst_ctrl", {62'd0, tx_enable, line_loopback_en}, 64'd1);

        axi_read(16'h0000, 2'b00, 32'h4554_4831, 0, 0);
        axi_read(16'h0008, 2'b00, 32'h0000_0001, 0, 0);
        axi_read(16'h0004, 2'b00, 32'h0000_005A, 0, 0);

        axi_write(16'h0008, 32'h0, 4'hF, 1, 2'b00, 0, 1, 2'b00);
        axi_read(16'h0008, 2'b00, 32'h0, 0, 0);
        axi_write(16'h0008, 32'hFFFF_FFFE, 4'h1, 0, 2'b00, 0, 1, 2'b10);
        axi_read(16'h0008, 2'b00, 32'h2, 0, 0);

        axi_write(16'h000C, 32'hAABB_CCDD, 4'b0101, 2, 2'b00, 0, 0, 2'b00);
        axi_read(16'h000C, 2'b00, 32'h00BB_00DD, 0, 0);

        axi_write(16'h0000, 32'hFFFF_FFFF, 4'hF, 0, 2'b10, 0, 1, 2'b10);
        axi_write(16'h0018, 32'hFFFF_FFFF, 4'hF, 1, 2'b10, 0, 0, 2'b00);
        axi_read(16'h001C, 2'b10, 32'h0, 0, 0);
        axi_read(16'h0000, 2'b00, 32'h4554_4831, 0, 0);
        axi_read(16'h000C, 2'b00, 32'h00BB_00DD, 0, 0);

        frame_pulses(5);
`ifdef ETH_PORT_CTRL_FRAME_CNT_EN
        axi_read(16'h0010, 2'b00, 32'd5, 0, 0);
        axi_read(16'h0010, 2'b00, 32'd0, 0, 1);
        axi_read(16'h0010, 2'b00, 32'd1, 0, 0);
`else
        axi_read(16'h0010, 2'b10, 32'd0, 0, 0);
        axi_read(16'h0010, 2'b10, 32'd0, 0, 1);
`endif

        axi_write(16'h000C, 32'h1234_5678, 4'hF, 0, 2'b00, 10, 0, 2'b00);
        axi_read(16'h000C, 2'b00, 32'h1234_5678, 10, 0);

        // Reset with both responses outstanding: neither may be emitted.
        s_axi_bready = 1'b0; s_axi_rready = 1'b0;
        s_axi_awaddr = 16'h0008; s_axi_wdata = 32'h3; s_axi_wstrb = 4'hF;
        s_axi_awvalid = 1'b1; s_axi_wvalid = 1'b1;
        s_axi_araddr = 16'h0000; s_axi_arvalid = 1'b1;
        @(posedge aclk); #1;
        s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0; s_axi_arvalid = 1'b0;
        check_eq("pre_rst_valid", {62'd0, s_axi_bvalid, s_axi_rvalid}, 64'd3);
        areset = 1'b1;
        @(posedge aclk); #1;
        check_eq("mid_rst_valid", {62'd0, s_axi_bvalid, s_axi_rvalid}, 64'd0);
        check_eq("mid_rst_ready", {61'd0, s_axi_awready, s_axi_wready, s_axi_arready}, 64'd7);
        check_eq("mid_rst_ctrl", {62'd0, tx_enable, line_loopback_en}, 64'd1);
        areset = 1'b0;
        s_axi_bready = 1'b1; s_axi_rready = 1'b1;
        axi_read(16'h000C, 2'b00, 32'h0, 0, 0);

        repeat (3) @(posedge aclk);
        check_eq("sb_drain", {32'd0, exp_b.size(), 16'd0} | {48'd0, 16'(exp_r.size())}, 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
